lsu_mem_ctrl: RTL and testbench

LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

---
 rtl/lsu_mem_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl
// Load/store unit front end that turns one CPU access request into a single
// word-wide bus transaction. Stores are lane-replicated with byte strobes and
// loads are byte/halfword selected and sign/zero extended on the way back.
// Misaligned, illegal or conflicting requests are answered with an error
// response without touching the bus; a stalled bus access is aborted after
// TIMEOUT_CYC cycles.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid / req_ready   request handshake (ready only while idle)
//   write_mem [1:0]         store code: 00 none, 01 sw, 10 sh, 11 sb
//   read_mem  [2:0]         load code: 001 lw, 110 lh, 111 lb, 011 lbu, 010 lhu
//   addr, wdata [31:0]      byte address and right-aligned store data
//   resp_valid / resp_err   one-cycle completion pulse and its error flag
//   rdata [31:0]            formatted load result
//   bus_req/we/addr/wstrb/wdata   word bus request, held until bus_ack
//   bus_ack, bus_rdata      bus completion and full-word read data
module lsu_mem_ctrl #(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  write_mem,
   input  logic [2:0]  read_mem,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] rdata,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_wstrb,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   state_t        state;
   logic [CW-1:0] wait_cnt;
   logic [2:0]    ld_code;
   logic [1:0]    byte_off;

   logic          is_load;
   logic          is_store;
   logic          req_err;
   logic [3:0]    strb_next;
   logic [31:0]   wdata_next;
   logic [7:0]    sel_byte;
   logic [15:0]   sel_half;
   logic [31:0]   fmt_rdata;
   logic          timeout_hit;

   // Decode the incoming request: error classification plus the strobes and
   // lane-replicated data the bus will see if the request is accepted.
   always_comb begin
      is_load    = (read_mem != 3'b000);
      is_store   = (write_mem != 2'b00);
      req_err    = 1'b0;
      strb_next  = 4'b0000;
      wdata_next = 32'h0;
      if (is_load && is_store)
         req_err = 1'b1;
      if (read_mem[2:1] == 2'b10)
         req_err = 1'b1;
      if (((read_mem == 3'b001) || (write_mem == 2'b01)) && (addr[1:0] != 2'b00))
         req_err = 1'b1;
      if (((read_mem == 3'b110) || (read_mem == 3'b010) || (write_mem == 2'b10)) && addr[0])
         req_err = 1'b1;
      case (write_mem)
         2'b01: begin
            strb_next  = 4'b1111;
            wdata_next = wdata;
         end
         2'b10: begin
            strb_next  = addr[1] ? 4'b1100 : 4'b0011;
            wdata_next = {2{wdata[15:0]}};
         end
         2'b11: begin
            strb_next  = 4'b0001 << addr[1:0];
            wdata_next = {4{wdata[7:0]}};
         end
         default: begin
            strb_next  = 4'b0000;
            wdata_next = 32'h0;
         end
      endcase
   end

   // Format the returned word using the latched load code and byte offset.
   // Stores latch a load code of 000, so they naturally return zero.
   always_comb begin
      sel_byte  = bus_rdata[{byte_off, 3'b000} +: 8];
      sel_half  = byte_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      fmt_rdata = 32'h0;
      case (ld_code)
         3'b001:  fmt_rdata = bus_rdata;
         3'b111:  fmt_rdata = {{24{sel_byte[7]}}, sel_byte};
         3'b011:  fmt_rdata = {24'h0, sel_byte};
         3'b110:  fmt_rdata = {{16{sel_half[15]}}, sel_half};
         3'b010:  fmt_rdata = {16'h0, sel_half};
         default: fmt_rdata = 32'h0;
      endcase
      timeout_hit = (wait_cnt == CW'(TIMEOUT_CYC - 1));
   end

   // Main controller. All outputs are registered; the bus request fields are
   // loaded once on acceptance and held untouched until the access ends, and
   // the timeout fires on the last permitted cycle so bus_req is high for
   // exactly TIMEOUT_CYC cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         ld_code    <= 3'b000;
         byte_off   <= 2'b00;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         rdata      <= 32'h0;
         bus_req    <= 1'b0;
         bus_we     <= 1'b0;
         bus_addr   <= 32'h0;
         bus_wstrb  <= 4'b0000;
         bus_wdata  <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && (is_load || is_store)) begin
                  req_ready <= 1'b0;
                  if (req_err) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     rdata      <= 32'h0;
                  end else begin
                     state     <= BUS;
                     wait_cnt  <= '0;
                     ld_code   <= read_mem;
                     byte_off  <= addr[1:0];
                     bus_req   <= 1'b1;
                     bus_we    <= is_store;
                     bus_addr  <= {addr[31:2], 2'b00};
                     bus_wstrb <= strb_next;
                     bus_wdata <= wdata_next;
                  end
               end
            end
            BUS: begin
               if (bus_ack || timeout_hit) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= !bus_ack;
                  rdata      <= bus_ack ? fmt_rdata : 32'h0;
                  bus_req    <= 1'b0;
                  bus_we     <= 1'b0;
                  bus_addr   <= 32'h0;
                  bus_wstrb  <= 4'b0000;
                  bus_wdata  <= 32'h0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            RESP: begin
               state      <= IDLE;
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               req_ready  <= 1'b1;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl
// Directed bench for lsu_mem_ctrl: a table of single-access vectors with
// hand-computed bus and response values, followed by hand-written sequences
// for dropped requests, stray acks, timeout and reset in the middle of an
// access. The DUT runs with TIMEOUT_CYC=4 so the timeout is short.
module tb_lsu_mem_ctrl;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  write_mem;
   logic [2:0]  read_mem;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] rdata;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   int n_checks;
   int n_fails;

   typedef struct {
      logic [1:0]  wm;
      logic [2:0]  rm;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rd;
      int          dly;
      logic        err;
      logic        we;
      logic [3:0]  strb;
      logic [31:0] bwdata;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[18];

   lsu_mem_ctrl #(.TIMEOUT_CYC(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .write_mem  (write_mem),
      .read_mem   (read_mem),
      .addr       (addr),
      .wdata      (wdata),
      .resp_valid (resp_valid),
      .resp_err   (resp_err),
      .rdata      (rdata),
      .bus_req    (bus_req),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_wstrb  (bus_wstrb),
      .bus_wdata  (bus_wdata),
      .bus_ack    (bus_ack),
      .bus_rdata  (bus_rdata)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fails++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Runs one access from IDLE to IDLE. Called 1 time unit after a rising
   // edge. While the access is on the bus the request inputs are scrambled
   // to show they are ignored outside IDLE.
   task automatic applyStimulus(input vec_t v, input string tag);
      checkOutput({tag, "_ready_idle"}, {31'h0, req_ready}, 32'h1);
      req_valid = 1'b1;
      write_mem = v.wm;
      read_mem  = v.rm;
      addr      = v.addr;
      wdata     = v.wdata;
      bus_ack   = 1'b0;
      nextCycle();
      if (v.err) begin
         req_valid = 1'b0;
         write_mem = 2'b00;
         read_mem  = 3'b000;
         checkOutput({tag, "_resp_valid"}, {31'h0, resp_valid}, 32'h1);
         checkOutput({tag, "_resp_err"}, {31'h0, resp_err}, 32'h1);
         checkOutput({tag, "_rdata"}, rdata, 32'h0);
         checkOutput({tag, "_bus_req"}, {31'h0, bus_req}, 32'h0);
         checkOutput({tag, "_ready_busy"}, {31'h0, req_ready}, 32'h0);
      end else begin
         write_mem = 2'b11;
         read_mem  = 3'b000;
         addr      = ~v.addr;
         wdata     = ~v.wdata;
         checkOutput({tag, "_bus_req"}, {31'h0, bus_req}, 32'h1);
         checkOutput({tag, "_bus_we"}, {31'h0, bus_we}, {31'h0, v.we});
         checkOutput({tag, "_bus_addr"}, bus_addr, {v.addr[31:2], 2'b00});
         checkOutput({tag, "_bus_wstrb"}, {28'h0, bus_wstrb}, {28'h0, v.strb});
         checkOutput({tag, "_bus_wdata"}, bus_wdata, v.bwdata);
         checkOutput({tag, "_ready_busy"}, {31'h0, req_ready}, 32'h0);
         for (int k = 0; k < v.dly; k++) begin
            nextCycle();
            checkOutput({tag, "_hold_req"}, {31'h0, bus_req}, 32'h1);
            checkOutput({tag, "_hold_addr"}, bus_addr, {v.addr[31:2], 2'b00});
            checkOutput({tag, "_hold_wstrb"}, {28'h0, bus_wstrb}, {28'h0, v.strb});
            checkOutput({tag, "_hold_wdata"}, bus_wdata, v.bwdata);
            checkOutput({tag, "_no_resp"}, {31'h0, resp_valid}, 32'h0);
         end
         bus_ack   = 1'b1;
         bus_rdata = v.rd;
         nextCycle();
         bus_ack   = 1'b0;
         req_valid = 1'b0;
         write_mem = 2'b00;
         checkOutput({tag, "_resp_valid"}, {31'h0, resp_valid}, 32'h1);
         checkOutput({tag, "_resp_err"}, {31'h0, resp_err}, 32'h0);
         checkOutput({tag, "_rdata"}, rdata, v.exp_rdata);
         checkOutput({tag, "_bus_req_off"}, {31'h0, bus_req}, 32'h0);
      end
      nextCycle();
      checkOutput({tag, "_resp_done"}, {31'h0, resp_valid}, 32'h0);
      checkOutput({tag, "_ready_back"}, {31'h0, req_ready}, 32'h1);
      checkOutput({tag, "_bus_idle"}, {31'h0, bus_req}, 32'h0);
   endtask

   initial begin
      int   bus_cycles;
      vec_t v_lbu;
      n_checks  = 0;
      n_fails   = 0;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      write_mem = 2'b00;
      read_mem  = 3'b000;
      addr      = 32'h0;
      wdata     = 32'h0;
      bus_ack   = 1'b0;
      bus_rdata = 32'h0;

      //          wm     rm      addr          wdata         bus_rdata   dly err we strb     bus_wdata     rdata
      vecs[0]  = '{2'b00, 3'b111, 32'h0000_1003, 32'h0,        32'h80FF_FF00, 0, 0, 0, 4'b0000, 32'h0,        32'hFFFF_FF80};
      vecs[1]  = '{2'b10, 3'b000, 32'h0000_2002, 32'h1234_ABCD, 32'h0,       2, 0, 1, 4'b1100, 32'hABCD_ABCD, 32'h0};
      vecs[2]  = '{2'b00, 3'b001, 32'h0000_3001, 32'h0,        32'h0,        0, 1, 0, 4'b0000, 32'h0,        32'h0};
      vecs[3]  = '{2'b01, 3'b001, 32'h0000_0000, 32'h0,        32'h0,        0, 1, 0, 4'b0000, 32'h0,        32'h0};
      vecs[4]  = '{2'b01, 3'b000, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,       1, 0, 1, 4'b1111, 32'hDEAD_BEEF, 32'h0};
      vecs[5]  = '{2'b11, 3'b000, 32'h0000_0021, 32'h0000_005A, 32'h0,       0, 0, 1, 4'b0010, 32'h5A5A_5A5A, 32'h0};
      vecs[6]  = '{2'b00, 3'b110, 32'h0000_0042, 32'h0,        32'h8001_7FFF, 1, 0, 0, 4'b0000, 32'h0,        32'hFFFF_8001};
      vecs[7]  = '{2'b00, 3'b010, 32'h0000_0040, 32'h0,        32'h1234_F00D, 0, 0, 0, 4'b0000, 32'h0,        32'h0000_F00D};
      vecs[8]  = '{2'b00, 3'b011, 32'h0000_0051, 32'h0,        32'h0000_9A00, 0, 0, 0, 4'b0000, 32'h0,        32'h0000_009A};
      vecs[9]  = '{2'b00, 3'b001, 32'h0000_0060, 32'h0,        32'hCAFE_F00D, 2, 0, 0, 4'b0000, 32'h0,        32'hCAFE_F00D};
      vecs[10] = '{2'b00, 3'b100, 32'h0000_0070, 32'h0,        32'h0,        0, 1, 0, 4'b0000, 32'h0,        32'h0};
      vecs[11] = '{2'b00, 3'b101, 32'h0000_0070, 32'h0,        32'h0,        0, 1, 0, 4'b0000, 32'h0,        32'h0};
      vecs[12] = '{2'b00, 3'b110, 32'h0000_0041, 32'h0,        32'h0,        0, 1, 0, 4'b0000, 32'h0,        32'h0};
      vecs[13] = '{2'b10, 3'b000, 32'h0000_0043, 32'h0,        32'h0,        0, 1, 0, 4'b0000, 32'h0,        32'h0};
      vecs[14] = '{2'b01, 3'b000, 32'h0000_0002, 32'h0,        32'h0,        0, 1, 0, 4'b0000, 32'h0,        32'h0};
      vecs[15] = '{2'b00, 3'b111, 32'h0000_0001, 32'h0,        32'h0000_7F00, 0, 0, 0, 4'b0000, 32'h0,        32'h0000_007F};
      vecs[16] = '{2'b11, 3'b000, 32'h0000_0003, 32'hFFFF_FF11, 32'h0,       1, 0, 1, 4'b1000, 32'h1111_1111, 32'h0};
      vecs[17] = '{2'b00, 3'b010, 32'h0000_0042, 32'h0,        32'h8001_0000, 0, 0, 0, 4'b0000, 32'h0,        32'h0000_8001};

      // Reset values while rst_n is held low.
      @(posedge clk);
      #1;
      checkOutput("rst_ready", {31'h0, req_ready}, 32'h1);
      checkOutput("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
      checkOutput("rst_resp_err", {31'h0, resp_err}, 32'h0);
      checkOutput("rst_bus_req", {31'h0, bus_req}, 32'h0);
      checkOutput("rst_bus_we", {31'h0, bus_we}, 32'h0);
      checkOutput("rst_rdata", rdata, 32'h0);
      checkOutput("rst_bus_addr", bus_addr, 32'h0);
      checkOutput("rst_bus_wstrb", {28'h0, bus_wstrb}, 32'h0);
      checkOutput("rst_bus_wdata", bus_wdata, 32'h0);
      rst_n = 1'b1;
      nextCycle();

      for (int i = 0; i < 18; i++)
         applyStimulus(vecs[i], $sformatf("v%0d", i));

      // A request with no load or store code is dropped.
      req_valid = 1'b1;
      nextCycle();
      req_valid = 1'b0;
      checkOutput("drop_ready", {31'h0, req_ready}, 32'h1);
      checkOutput("drop_resp", {31'h0, resp_valid}, 32'h0);
      checkOutput("drop_bus_req", {31'h0, bus_req}, 32'h0);

      // A stray ack in IDLE does nothing.
      bus_ack = 1'b1;
      nextCycle();
      nextCycle();
      bus_ack = 1'b0;
      checkOutput("stray_ack_resp", {31'h0, resp_valid}, 32'h0);
      checkOutput("stray_ack_ready", {31'h0, req_ready}, 32'h1);
      checkOutput("stray_ack_rdata", rdata, 32'h0000_8001);

      // lhu with no ack: bus_req for exactly 4 cycles, then an error response;
      // an ack arriving during the response is ignored.
      req_valid = 1'b1;
      read_mem  = 3'b010;
      addr      = 32'h0000_0100;
      nextCycle();
      req_valid  = 1'b0;
      read_mem   = 3'b000;
      bus_cycles = 0;
      for (int k = 0; k < 10 && !resp_valid; k++) begin
         if (bus_req)
            bus_cycles++;
         nextCycle();
      end
      checkOutput("to_bus_cycles", bus_cycles, 32'd4);
      checkOutput("to_resp_valid", {31'h0, resp_valid}, 32'h1);
      checkOutput("to_resp_err", {31'h0, resp_err}, 32'h1);
      checkOutput("to_rdata", rdata, 32'h0);
      checkOutput("to_bus_req_off", {31'h0, bus_req}, 32'h0);
      bus_ack   = 1'b1;
      bus_rdata = 32'hFFFF_FFFF;
      nextCycle();
      bus_ack = 1'b0;
      checkOutput("to_late_ack_resp", {31'h0, resp_valid}, 32'h0);
      checkOutput("to_late_ack_ready", {31'h0, req_ready}, 32'h1);
      checkOutput("to_late_ack_rdata", rdata, 32'h0);
      nextCycle();
      checkOutput("to_after_resp", {31'h0, resp_valid}, 32'h0);
      checkOutput("to_after_bus_req", {31'h0, bus_req}, 32'h0);

      // Reset while the bus access is pending aborts it silently.
      req_valid = 1'b1;
      read_mem  = 3'b001;
      addr      = 32'h0000_0080;
      nextCycle();
      req_valid = 1'b0;
      read_mem  = 3'b000;
      checkOutput("mid_rst_bus_req_before", {31'h0, bus_req}, 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_bus_req", {31'h0, bus_req}, 32'h0);
      checkOutput("mid_rst_ready", {31'h0, req_ready}, 32'h1);
      checkOutput("mid_rst_resp", {31'h0, resp_valid}, 32'h0);
      checkOutput("mid_rst_bus_addr", bus_addr, 32'h0);
      nextCycle();
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         nextCycle();
         checkOutput("post_rst_resp", {31'h0, resp_valid}, 32'h0);
         checkOutput("post_rst_bus_req", {31'h0, bus_req}, 32'h0);
      end
      v_lbu = '{2'b00, 3'b011, 32'h0000_4001, 32'h0, 32'h0000_9A00, 0, 0, 0,
                4'b0000, 32'h0, 32'h0000_009A};
      applyStimulus(v_lbu, "post_rst_lbu");

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
